sprite_serializer: RTL and testbench
====================================

Name: sprite_serializer

Overview:
- Upstream neighbour of the sprite line buffer. Accepts one fetched 16-pixel sprite row per handshake: 4 bitplanes, palette, X start, h-flip and horizontal shrink mask.
- Serializes the row into per-pixel 4-bit color indexes. Generates the address reload, address step and write strobes that the line buffer consumes.
- Sits between the sprite graphics fetch and the line buffer, in the CLK domain, paced by the pixel clock enable.

Parameters:
- FIFO_DEPTH, 2, number of sprite-row entries buffered ahead of the serializer (power of two, minimum 2).
- X_W, 8, line buffer address width.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous active-high reset
- PIX_EN  in  1  pixel-slot clock enable; one serializer slot per CLK cycle with PIX_EN=1
- FLUSH  in  1  start-of-line discard; synchronous, one cycle
- IN_VALID  in  1  sprite row offered
- IN_READY  out  1  FIFO can accept a row
- IN_PLANES  in  64  plane p at bits [16p+15:16p]; bit 15 of each plane is the leftmost pixel
- IN_PAL  in  8  sprite palette
- IN_X  in  X_W  line buffer start address
- IN_HFLIP  in  1  1 = bit 0 is the leftmost pixel
- IN_SHRINK  in  16  keep mask, bit 15 = leftmost source pixel, 1 = pixel kept
- LB_RELOAD  out  1  one-slot pulse; line buffer loads LB_ADDR_LOAD
- LB_ADDR_LOAD  out  X_W  reload address (IN_X of the current row)
- LB_STEP  out  1  advance line buffer address after this slot
- LB_WR  out  1  write COLOR_INDEX/SPR_PAL at the current address this slot
- COLOR_INDEX  out  4  pixel color index
- SPR_PAL  out  8  palette of the row being serialized
- BUSY  out  1  FIFO non-empty or row in progress

Behaviour:
- Reset: FIFO empty, FSM IDLE. LB_RELOAD, LB_STEP, LB_WR = 0. COLOR_INDEX = 0, SPR_PAL = 0, LB_ADDR_LOAD = 0. IN_READY = 1, BUSY = 0. Reset mid-row abandons the row with no further strobes.
- FIFO:
  - Push when IN_VALID & IN_READY.
  - IN_READY = not full. It is combinational on occupancy only, never on IN_VALID.
  - Push while full is impossible by the handshake.
  - Push and pop in the same cycle keep the count unchanged.
- FSM IDLE -> RELOAD:
  - At a PIX_EN cycle with the FIFO non-empty, pop the head into the row register.
  - Pixel order is resolved at pop: HFLIP reverses the pixel order of all 4 planes and the shrink mask together.
  - Outputs that slot: LB_RELOAD = 1, LB_ADDR_LOAD = X, SPR_PAL = PAL. LB_WR = 0, LB_STEP = 0.
- RELOAD -> PIXEL: slot counter starts at 0.
- PIXEL: one source pixel per PIX_EN, slots 0..15.
  - COLOR_INDEX = {plane3,plane2,plane1,plane0} bits of that pixel.
  - LB_STEP = shrink bit of the pixel.
  - LB_WR = shrink bit & (COLOR_INDEX != 0). Index 0 is transparent and is not written, but the address still steps.
  - Dropped pixels (shrink bit 0): LB_STEP = 0, LB_WR = 0; the slot is still consumed.
- After slot 15: go to RELOAD if the FIFO is non-empty (pop in that same slot, back-to-back), else IDLE. A row therefore occupies exactly 17 PIX_EN slots.
- Strobe timing: all strobes are registered and valid for exactly one CLK cycle, the cycle after the PIX_EN cycle that produced them. They are 0 in every other cycle.
- PIX_EN = 0: FSM frozen; pushes still accepted.
- Address wrap: the line buffer address is X_W bits and wraps modulo 2^X_W. The serializer only passes X through and does not clip.
- FLUSH:
  - Empties the FIFO, returns the FSM to IDLE and suppresses strobes from the next cycle.
  - Has priority over a simultaneous push (the push is dropped) and over a pop.
  - IN_READY is 1 in the cycle after FLUSH.
- BUSY = FIFO count != 0 or FSM != IDLE.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, RELOAD, PIXEL);
  - the sprite-row struct {planes[63:0], pal[7:0], x[X_W-1:0], hflip, shrink[15:0]};
  - constant PIX_PER_ROW = 16;
  - constant TRANSPARENT_IDX = 4'h0.
- One sub-module: sprite_row_fifo, a generic FIFO_DEPTH-entry FIFO with valid/ready push, pop and synchronous flush.
- The serializer FSM and pixel selection stay in the top module.

Test Plan:
- Single row: X=8'h20, PAL=8'h5A, planes giving indexes 1..15,0 left-to-right, shrink=16'hFFFF, PIX_EN always 1.
  - Expect one LB_RELOAD with ADDR=8'h20, SPR_PAL=8'h5A.
  - Then 16 LB_STEP pulses; LB_WR on the first 15 with COLOR_INDEX 1..15; slot 16 has LB_WR=0.
- HFLIP: same row with IN_HFLIP=1 -> COLOR_INDEX sequence 0,15,14..1; first slot LB_WR=0, LB_STEP=1.
- Shrink: IN_SHRINK=16'hAAAA -> 8 slots with LB_STEP=1, LB_WR=1 (even source pixels 0,2,...,14), 8 slots with LB_STEP=0, LB_WR=0.
- Back-to-back and backpressure: push 3 rows with FIFO_DEPTH=2.
  - IN_READY drops after 2 pushes and rises after the first pop.
  - Reloads arrive exactly 17 PIX_EN slots apart with no idle slot.
- PIX_EN every 4th cycle: strobes only in the cycle after each PIX_EN; total 17 strobe slots over 68 cycles.
- FLUSH at slot 7 with 1 row queued and a simultaneous push: no strobes afterwards, BUSY=0, IN_READY=1 next cycle.
- RESET asserted mid-row: all outputs 0 immediately (asynchronous); after release, the FSM is IDLE and the FIFO empty.

Source files
------------

// File: rtl/sprite_serializer_pkg.sv
// Shared types and constants for the sprite row serializer.
// Flip resolution lives here so the FIFO stays generic.
package sprite_serializer_pkg;

    localparam int LB_X_W = 8;
    localparam int PIX_PER_ROW = 16;
    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        RELOAD,
        PIXEL
    } state_t;

    typedef struct packed {
        logic [63:0]       planes;
        logic [7:0]        pal;
        logic [LB_X_W-1:0] x;
        logic              hflip;
        logic [15:0]       shrink;
    } row_t;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

    // Mirror planes and keep mask together so slot 0 is always bit 15.
    function automatic row_t resolve(input row_t r);
        row_t o;
        o = r;
        if (r.hflip) begin
            for (int p = 0; p < 4; p++) begin
                o.planes[16*p +: 16] = rev16(r.planes[16*p +: 16]);
            end
            o.shrink = rev16(r.shrink);
        end
        return o;
    endfunction

endpackage

// File: rtl/sprite_serializer_if.sv
// Sprite row push bus and line buffer strobe bus.
// master drives rows and observes strobes; slave is the serializer.
interface sprite_serializer_if #(
    parameter int X_W = 8
);
    logic           IN_VALID;
    logic           IN_READY;
    logic [63:0]    IN_PLANES;
    logic [7:0]     IN_PAL;
    logic [X_W-1:0] IN_X;
    logic           IN_HFLIP;
    logic [15:0]    IN_SHRINK;

    logic           LB_RELOAD;
    logic [X_W-1:0] LB_ADDR_LOAD;
    logic           LB_STEP;
    logic           LB_WR;
    logic [3:0]     COLOR_INDEX;
    logic [7:0]     SPR_PAL;

    modport master (
        output IN_VALID, IN_PLANES, IN_PAL, IN_X,
        output IN_HFLIP, IN_SHRINK,
        input  IN_READY,
        input  LB_RELOAD, LB_ADDR_LOAD, LB_STEP,
        input  LB_WR, COLOR_INDEX, SPR_PAL
    );

    modport slave (
        input  IN_VALID, IN_PLANES, IN_PAL, IN_X,
        input  IN_HFLIP, IN_SHRINK,
        output IN_READY,
        output LB_RELOAD, LB_ADDR_LOAD, LB_STEP,
        output LB_WR, COLOR_INDEX, SPR_PAL
    );
endinterface

// File: rtl/sprite_serializer_fifo.sv
// Generic valid/ready FIFO with synchronous flush.
// Flush wins over both push and pop in the same cycle.
module sprite_row_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_ready = (count != (AW+1)'(DEPTH));
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push_valid & push_ready & ~flush;
    assign do_pop     = pop & pop_valid & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sprite_serializer.sv
// Serializes buffered sprite rows into per-pixel color indexes
// and line buffer reload/step/write strobes, one pixel per PIX_EN.
module sprite_serializer
    import sprite_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int X_W        = LB_X_W
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PIX_EN,
    input  logic FLUSH,
    output logic BUSY,
    sprite_serializer_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = $bits(row_t);

    row_t          in_row;
    row_t          head;
    row_t          res;
    logic [RW-1:0] head_bits;
    logic          head_valid;
    logic          pop;
    logic [CW-1:0] count;

    state_t         state_q, state_d;
    logic [3:0]     slot_q, slot_d;
    logic [63:0]    planes_q, planes_d;
    logic [15:0]    shrink_q, shrink_d;
    logic [7:0]     pal_q, pal_d;
    logic [X_W-1:0] x_q, x_d;
    logic [3:0]     pix;
    logic [3:0]     cur_idx;
    logic           keep;

    logic           reload_q, reload_d;
    logic           step_q, step_d;
    logic           wr_q, wr_d;
    logic [X_W-1:0] addr_q, addr_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     spal_q, spal_d;

    assign in_row = '{
        planes: bus.IN_PLANES,
        pal:    bus.IN_PAL,
        x:      bus.IN_X,
        hflip:  bus.IN_HFLIP,
        shrink: bus.IN_SHRINK
    };

    sprite_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RESET),
        .flush      (FLUSH),
        .push_valid (bus.IN_VALID),
        .push_ready (bus.IN_READY),
        .push_data  (in_row),
        .pop        (pop),
        .pop_valid  (head_valid),
        .pop_data   (head_bits),
        .count      (count)
    );

    assign head = row_t'(head_bits);
    assign res  = resolve(head);

    // Slot 0 reads bit 15, the leftmost pixel after flip resolution.
    assign pix     = 4'(PIX_PER_ROW - 1) - slot_q;
    assign cur_idx = {planes_q[{2'd3, pix}], planes_q[{2'd2, pix}],
                      planes_q[{2'd1, pix}], planes_q[{2'd0, pix}]};
    assign keep    = shrink_q[pix];

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        planes_d = planes_q;
        shrink_d = shrink_q;
        pal_d    = pal_q;
        x_d      = x_q;
        pop      = 1'b0;
        reload_d = 1'b0;
        step_d   = 1'b0;
        wr_d     = 1'b0;
        addr_d   = '0;
        idx_d    = '0;
        spal_d   = '0;
        if (FLUSH) begin
            state_d = IDLE;
        end else if (PIX_EN) begin
            unique case (state_q)
                IDLE: begin
                    if (head_valid) begin
                        pop      = 1'b1;
                        planes_d = res.planes;
                        shrink_d = res.shrink;
                        pal_d    = res.pal;
                        x_d      = res.x;
                        reload_d = 1'b1;
                        addr_d   = res.x;
                        spal_d   = res.pal;
                        slot_d   = '0;
                        state_d  = PIXEL;
                    end
                end
                RELOAD: begin
                    reload_d = 1'b1;
                    addr_d   = x_q;
                    spal_d   = pal_q;
                    slot_d   = '0;
                    state_d  = PIXEL;
                end
                PIXEL: begin
                    idx_d  = cur_idx;
                    spal_d = pal_q;
                    step_d = keep;
                    wr_d   = keep && (cur_idx != TRANSPARENT_IDX);
                    slot_d = slot_q + 4'd1;
                    if (slot_q == 4'(PIX_PER_ROW - 1)) begin
                        // Pop the next row now; its reload takes the next slot.
                        if (head_valid) begin
                            pop      = 1'b1;
                            planes_d = res.planes;
                            shrink_d = res.shrink;
                            pal_d    = res.pal;
                            x_d      = res.x;
                            state_d  = RELOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            planes_q <= '0;
            shrink_q <= '0;
            pal_q    <= '0;
            x_q      <= '0;
            reload_q <= 1'b0;
            step_q   <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            idx_q    <= '0;
            spal_q   <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            planes_q <= planes_d;
            shrink_q <= shrink_d;
            pal_q    <= pal_d;
            x_q      <= x_d;
            reload_q <= reload_d;
            step_q   <= step_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            spal_q   <= spal_d;
        end
    end

    assign bus.LB_RELOAD    = reload_q;
    assign bus.LB_ADDR_LOAD = addr_q;
    assign bus.LB_STEP      = step_q;
    assign bus.LB_WR        = wr_q;
    assign bus.COLOR_INDEX  = idx_q;
    assign bus.SPR_PAL      = spal_q;

    assign BUSY = (count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_sprite_serializer.sv
// Scoreboard bench for sprite_serializer: row table plus
// backpressure, slow pixel enable, flush and reset sequences.
module tb_sprite_serializer;

    typedef struct {
        logic [63:0] planes;
        logic [7:0]  pal;
        logic [7:0]  x;
        logic        hflip;
        logic [15:0] shrink;
        int          exp_steps;
        int          exp_wrs;
    } vec_t;

    typedef struct {
        bit         reload;
        logic [7:0] addr;
        logic [7:0] pal;
        bit         step;
        bit         wr;
        logic [3:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    logic flush = 1'b0;
    logic busy;

    sprite_serializer_if #(.X_W(8)) bus ();

    sprite_serializer #(
        .FIFO_DEPTH (2),
        .X_W        (8)
    ) dut (
        .CLK    (clk),
        .RESET  (rst),
        .PIX_EN (pix_en),
        .FLUSH  (flush),
        .BUSY   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mode = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int reload_slots[$];
    int wait_cnt = 0;
    int slot_no = 0;
    int step_cnt = 0;
    int wr_cnt = 0;
    int strobe_cycles = 0;
    int last_wait = 0;
    logic pe_s, rst_s, strobe;
    exp_t e;

    function automatic void chk(input string name,
                                input longint act,
                                input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, req, $time);
        end
    endfunction

    // Pixel enable pattern: 0 off, 1 always, 2 every 4th cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (mode)
            0: pix_en = 1'b0;
            1: pix_en = 1'b1;
            default: pix_en = (cyc % 4 == 0);
        endcase
    end

    always @(posedge clk) begin
        pe_s = pix_en;
        rst_s = rst;
        #2;
        if (!rst_s && !rst) begin
            strobe = bus.LB_RELOAD | bus.LB_STEP | bus.LB_WR;
            if (strobe) strobe_cycles++;
            if (bus.LB_STEP) step_cnt++;
            if (bus.LB_WR) wr_cnt++;
            if (!pe_s) begin
                chk("gap_strobe", strobe, 0);
            end else begin
                slot_no++;
                if (bus.LB_RELOAD) reload_slots.push_back(slot_no);
                if (exp_q.size() == 0) begin
                    chk("spurious_strobe", strobe, 0);
                end else if (exp_q[0].reload && !bus.LB_RELOAD) begin
                    chk("pre_reload_strobe", strobe, 0);
                    wait_cnt++;
                    if (wait_cnt > 40) begin
                        chk("reload_timeout", 0, 1);
                        exp_q.delete();
                        wait_cnt = 0;
                    end
                end else begin
                    e = exp_q.pop_front();
                    wait_cnt = 0;
                    chk("reload", bus.LB_RELOAD, e.reload);
                    chk("step", bus.LB_STEP, e.step);
                    chk("wr", bus.LB_WR, e.wr);
                    if (e.reload) chk("addr", bus.LB_ADDR_LOAD, e.addr);
                    else chk("color_index", bus.COLOR_INDEX, e.idx);
                    if (e.reload || e.wr) chk("spr_pal", bus.SPR_PAL, e.pal);
                end
            end
        end
    end

    function automatic logic [63:0] ramp();
        logic [63:0] r;
        logic [3:0] v;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            v = 4'(k + 1);
            for (int p = 0; p < 4; p++) r[16*p + 15 - k] = v[p];
        end
        return r;
    endfunction

    function automatic void push_expect(input vec_t v);
        exp_t x;
        int b;
        logic [3:0] idx;
        x = '{reload: 1, addr: v.x, pal: v.pal,
              step: 0, wr: 0, idx: 4'h0};
        exp_q.push_back(x);
        for (int s = 0; s < 16; s++) begin
            b = v.hflip ? s : 15 - s;
            idx = {v.planes[48+b], v.planes[32+b],
                   v.planes[16+b], v.planes[b]};
            x = '{reload: 0, addr: 8'h00, pal: v.pal,
                  step: v.shrink[b],
                  wr: v.shrink[b] && (idx != 4'h0), idx: idx};
            exp_q.push_back(x);
        end
    endfunction

    task automatic drive_row(input vec_t v);
        bus.IN_VALID = 1'b1;
        bus.IN_PLANES = v.planes;
        bus.IN_PAL = v.pal;
        bus.IN_X = v.x;
        bus.IN_HFLIP = v.hflip;
        bus.IN_SHRINK = v.shrink;
    endtask

    task automatic push_row(input vec_t v);
        int w;
        w = 0;
        while (!bus.IN_READY && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        last_wait = w;
        if (!bus.IN_READY) begin
            chk("push_ready_timeout", 0, 1);
        end else begin
            drive_row(v);
            push_expect(v);
            @(posedge clk); #1;
            bus.IN_VALID = 1'b0;
        end
    endtask

    task automatic drain(input int max);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < max) begin
            @(posedge clk); #1;
            w++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_q_le(input int lim);
        int w;
        w = 0;
        do begin
            @(posedge clk); #3;
            w++;
        end while (exp_q.size() > lim && w < 200);
        chk("wait_slot_timeout", exp_q.size() <= lim, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reload"}, bus.LB_RELOAD, 0);
        chk({tag, "_step"}, bus.LB_STEP, 0);
        chk({tag, "_wr"}, bus.LB_WR, 0);
        chk({tag, "_idx"}, bus.COLOR_INDEX, 0);
        chk({tag, "_pal"}, bus.SPR_PAL, 0);
        chk({tag, "_addr"}, bus.LB_ADDR_LOAD, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, bus.IN_READY, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t ramp_v;
        logic [63:0] rp;

        bus.IN_VALID = 1'b0;
        bus.IN_PLANES = '0;
        bus.IN_PAL = '0;
        bus.IN_X = '0;
        bus.IN_HFLIP = 1'b0;
        bus.IN_SHRINK = '0;

        rp = ramp();
        tbl[0] = '{rp, 8'h5A, 8'h20, 1'b0, 16'hFFFF, 16, 15};
        tbl[1] = '{rp, 8'h5A, 8'h20, 1'b1, 16'hFFFF, 16, 15};
        tbl[2] = '{rp, 8'h33, 8'h40, 1'b0, 16'hAAAA, 8, 8};
        tbl[3] = '{rp, 8'h34, 8'h41, 1'b1, 16'hAAAA, 8, 8};
        tbl[4] = '{64'h0, 8'h11, 8'h10, 1'b0, 16'hFFFF, 16, 0};
        tbl[5] = '{{4{16'hFFFF}}, 8'hC3, 8'hFF, 1'b0,
                   16'h0F0F, 8, 8};
        tbl[6] = '{rp, 8'h77, 8'h00, 1'b0, 16'h0000, 0, 0};
        tbl[7] = '{{4{16'h00FF}}, 8'h9E, 8'h80, 1'b1,
                   16'hFFFF, 16, 8};
        ramp_v = tbl[0];

        #3;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_reset_busy", busy, 0);
        mode = 1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            step_cnt = 0;
            wr_cnt = 0;
            push_row(tbl[i]);
            drain(200);
            chk($sformatf("row%0d_steps", i), step_cnt, tbl[i].exp_steps);
            chk($sformatf("row%0d_wrs", i), wr_cnt, tbl[i].exp_wrs);
            chk($sformatf("row%0d_idle", i), busy, 0);
        end

        // Backpressure: two rows fill the FIFO while the pixel clock is off.
        mode = 0;
        repeat (2) @(posedge clk);
        #1;
        reload_slots.delete();
        push_row(tbl[0]);
        push_row(tbl[2]);
        chk("ready_full", bus.IN_READY, 0);
        chk("busy_full", busy, 1);
        mode = 1;
        push_row(tbl[7]);
        chk("ready_rise_wait", (last_wait >= 1) && (last_wait <= 2), 1);
        drain(300);
        chk("b2b_reload_count", reload_slots.size(), 3);
        if (reload_slots.size() == 3) begin
            chk("b2b_gap1", reload_slots[1] - reload_slots[0], 17);
            chk("b2b_gap2", reload_slots[2] - reload_slots[1], 17);
        end

        // Slow pixel enable: 17 strobe slots spread over 68 cycles.
        mode = 2;
        repeat (4) @(posedge clk);
        #1;
        strobe_cycles = 0;
        push_row(ramp_v);
        repeat (90) @(posedge clk);
        #1;
        chk("slow_pe_strobes", strobe_cycles, 17);
        chk("slow_pe_drained", exp_q.size(), 0);
        mode = 1;
        repeat (3) @(posedge clk);
        #1;

        // Flush at pixel slot 7 with one row queued and a push in flight.
        push_row(tbl[0]);
        push_row(tbl[1]);
        wait_q_le(26);
        flush = 1'b1;
        drive_row(tbl[2]);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.IN_VALID = 1'b0;
        exp_q.delete();
        wait_cnt = 0;
        chk("flush_busy", busy, 0);
        chk("flush_ready", bus.IN_READY, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("flush_busy_late", busy, 0);

        // Asynchronous reset in the middle of a row.
        push_row(tbl[0]);
        wait_q_le(10);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        wait_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_busy", busy, 0);
        chk("rel_ready", bus.IN_READY, 1);
        repeat (30) @(posedge clk);
        #1;
        step_cnt = 0;
        wr_cnt = 0;
        push_row(tbl[0]);
        drain(200);
        chk("after_reset_steps", step_cnt, 16);
        chk("after_reset_wrs", wr_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
